// File: rtl/hcx_core.sv
// hcx_core: parametrised single-edge FETCH/EXEC stack CPU with external program ROM and data RAM.
// Optional debug taps (dbg_pc, dbg_instr, dbg_alu) are compiled in only when HCX_DEBUG_EN is defined.
module hcx_core #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned STACK_DEPTH = 3,
  parameter int unsigned PC_W        = 12
) (
  input  logic                  clk,
  input  logic                  nReset,
  output logic [PC_W-1:0]       imem_addr,
  output logic                  imem_req,
  input  logic                  imem_ready,
  input  logic [7:0]            imem_rdata,
  output logic [2*DATA_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic                  dmem_we,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  halted
`ifdef HCX_DEBUG_EN
  ,
  output logic [PC_W-1:0]       dbg_pc,
  output logic [7:0]            dbg_instr,
  output logic [DATA_W-1:0]     dbg_alu
`endif
);

  localparam int unsigned AW  = 2 * DATA_W;
  localparam int unsigned DW1 = DATA_W + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   pc;
  logic [7:0]        instr;
  logic [DATA_W-1:0] stk [STACK_DEPTH];
  logic              c_flag;
  logic              z_flag;

  logic              is_write;
  logic              is_push;
  logic              is_halt;
  logic              jump_taken;
  logic              carry_nxt;
  logic [DATA_W-1:0] push_val;
  logic [DATA_W-1:0] alu;
  logic [AW-1:0]     mem_addr;
  logic [DW1-1:0]    sum;
  logic [DW1-1:0]    diff;
  logic [PC_W-1:0]   jump_pc;

  // Instruction decode and ALU, all from registered state.
  always_comb begin
    is_write   = ~instr[7];
    is_push    = (instr[7:5] == 3'b100) || (instr[7:4] == 4'b1010);
    is_halt    = (instr == 8'hBF);
    push_val   = instr[5] ? DATA_W'(instr[3:0]) : dmem_rdata;
    mem_addr   = (instr[6:4] == 3'b001) ? {stk[1], stk[0]} : AW'(instr[3:0]);
    sum        = {1'b0, stk[0]} + {1'b0, stk[1]};
    diff       = {1'b0, stk[0]} + {1'b0, ~stk[1]} + DW1'(1);
    jump_pc    = PC_W'({stk[2], stk[1], stk[0]});
    alu        = stk[0];
    carry_nxt  = c_flag;
    jump_taken = 1'b0;
    case (instr[6:4])
      3'b000: alu = stk[0];
      3'b001: alu = stk[2];
      3'b010: begin alu = sum[DATA_W-1:0];  carry_nxt = sum[DATA_W];  end
      3'b011: begin alu = diff[DATA_W-1:0]; carry_nxt = diff[DATA_W]; end
      3'b100: alu = stk[0] & stk[1];
      3'b101: alu = stk[0] | stk[1];
      3'b110: alu = stk[0] ^ stk[1];
      default: alu = ~(stk[0] | stk[1]);
    endcase
    if (instr[7:6] == 2'b11) begin
      case (instr[5:4])
        2'b00: jump_taken = 1'b1;
        2'b01: jump_taken = c_flag;
        2'b10: jump_taken = z_flag;
        default: jump_taken = ~z_flag;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= S_FETCH;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (imem_ready) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = is_halt ? S_HALT : S_FETCH;
      default: state_nxt = S_HALT;
    endcase
  end

  // Outputs; dmem_we decodes the state register so it falls with reset asynchronously.
  always_comb begin
    imem_req   = 1'b0;
    dmem_we    = 1'b0;
    halted     = 1'b0;
    imem_addr  = pc;
    dmem_addr  = mem_addr;
    dmem_wdata = alu;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC:  dmem_we  = is_write;
      default: halted   = 1'b1;
    endcase
  end

  // Datapath: instruction latch, pc, stack and flags.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc     <= '0;
      instr  <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else begin
      if (state == S_FETCH && imem_ready) instr <= imem_rdata;
      if (state == S_EXEC) begin
        pc <= jump_taken ? jump_pc : pc + PC_W'(1);
        if (is_write) begin
          z_flag <= (alu == '0);
          c_flag <= carry_nxt;
        end
        if (is_push) begin
          stk[0] <= push_val;
          for (int unsigned i = 1; i < STACK_DEPTH; i++) stk[i] <= stk[i-1];
        end
      end
    end
  end

`ifdef HCX_DEBUG_EN
  assign dbg_pc    = pc;
  assign dbg_instr = instr;
  assign dbg_alu   = alu;
`endif

endmodule

// File: tb/tb_hcx_core.sv
// Self-checking bench for hcx_core: directed test-plan sequences, then random programs checked
// against an arithmetic reference model of the instruction set.
module tb_hcx_core;

  logic        clk = 1'b0;
  logic        nReset;
  logic [11:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [7:0]  imem_rdata;
  logic [7:0]  dmem_addr;
  logic [3:0]  dmem_wdata;
  logic        dmem_we;
  logic [3:0]  dmem_rdata;
  logic        halted;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_pc;
  int m_c;
  int m_z;
  int m_stk [3];
  int m_ram [256];

  // Data RAM seen by the DUT.
  logic [3:0] ram [256];

  always #5 clk = ~clk;

  assign dmem_rdata = ram[dmem_addr];
  always @(posedge clk) if (dmem_we) ram[dmem_addr] <= dmem_wdata;

  hcx_core dut (
    .clk        (clk),
    .nReset     (nReset),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_c  = 0;
    m_z  = 0;
    for (int i = 0; i < 3; i++) m_stk[i] = 0;
  endtask

  task automatic model_push(input int v);
    m_stk[2] = m_stk[1];
    m_stk[1] = m_stk[0];
    m_stk[0] = v;
  endtask

  // Called at a negedge with the DUT in reset; releases it at the next negedge.
  task automatic do_reset();
    nReset     = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("rst_halted", halted, 0);
    chk("rst_pc", imem_addr, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_req", imem_req, 1);
    @(negedge clk);
    nReset = 1'b1;
    model_reset();
  endtask

  // Runs one instruction from a negedge in FETCH to the negedge of the next FETCH.
  task automatic run_instr(input logic [7:0] ins, input int waits);
    int op, lo, a, b, cl, addr, data, exp_we, is_mem, tgt, taken;
    chk("fetch_req", imem_req, 1);
    chk("fetch_pc", imem_addr, m_pc);
    chk("fetch_we", dmem_we, 0);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = 8'($urandom);
      @(negedge clk);
      chk("wait_req", imem_req, 1);
      chk("wait_pc", imem_addr, m_pc);
      chk("wait_we", dmem_we, 0);
    end
    imem_ready = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ready = 1'($urandom);
    imem_rdata = 8'($urandom);

    op = int'(ins) >> 4;
    lo = int'(ins) & 15;
    a = m_stk[0]; b = m_stk[1]; cl = m_stk[2];
    exp_we = 0; is_mem = 0; addr = 0; data = 0;
    if (op < 8) begin
      exp_we = 1; is_mem = 1;
      addr = (op == 1) ? b * 16 + a : lo;
      case (op)
        0: data = a;
        1: data = cl;
        2: data = (a + b) % 16;
        3: data = (a - b + 16) % 16;
        4: data = a & b;
        5: data = a | b;
        6: data = a ^ b;
        default: data = 15 - (a | b);
      endcase
    end else if (op == 8 || op == 9) begin
      is_mem = 1;
      addr = (op == 9) ? b * 16 + a : lo;
    end
    chk("exec_req", imem_req, 0);
    chk("exec_halted", halted, 0);
    chk("exec_we", dmem_we, exp_we);
    if (is_mem != 0) chk("exec_addr", dmem_addr, addr);
    if (exp_we != 0) chk("exec_wdata", dmem_wdata, data);

    taken = 0;
    tgt = (cl * 256 + b * 16 + a) % 4096;
    if (op < 8) begin
      m_ram[addr] = data;
      m_z = (data == 0) ? 1 : 0;
      if (op == 2) m_c = (a + b >= 16) ? 1 : 0;
      if (op == 3) m_c = (a >= b) ? 1 : 0;
    end else if (op == 8 || op == 9) begin
      model_push(m_ram[addr]);
    end else if (op == 10) begin
      model_push(lo);
    end else if (op >= 12) begin
      case (op & 3)
        0: taken = 1;
        1: taken = m_c;
        2: taken = m_z;
        default: taken = 1 - m_z;
      endcase
    end
    m_pc = (taken != 0) ? tgt : (m_pc + 1) % 4096;
    @(negedge clk);
    imem_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] ins;
    logic [3:0] saved;
    nReset     = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      m_ram[i] = int'($urandom_range(0, 15));
      ram[i]   = 4'(m_ram[i]);
    end
    @(negedge clk);
    do_reset();

    // LI 3; LI 5; ADD 0 -> 8 at dmem[0], C=0, Z=0, pc=3.
    run_instr(8'hA3, 0);
    run_instr(8'hA5, 0);
    run_instr(8'h20, 0);
    chk("add_ram0", ram[0], 4'h8);
    chk("add_pc", imem_addr, 12'h003);
    run_instr(8'hD0, 0);
    chk("add_jc_not_taken", imem_addr, 12'h004);
    run_instr(8'hF0, 0);
    chk("add_jnz_taken", imem_addr, 12'h035);

    // LI 5; LI 3; SUB 1 -> 0xE, C=0; LI 2; LI 2; SUB 1 -> 0, C=1, Z=1.
    run_instr(8'hA5, 0);
    run_instr(8'hA3, 0);
    run_instr(8'h31, 1);
    chk("sub_ram1_e", ram[1], 4'hE);
    run_instr(8'hD0, 0);
    chk("sub_jc_not_taken", imem_addr, 12'h039);
    run_instr(8'hA2, 0);
    run_instr(8'hA2, 0);
    run_instr(8'h31, 0);
    chk("sub_ram1_0", ram[1], 4'h0);
    run_instr(8'hE0, 0);
    chk("sub_jz_taken", imem_addr, 12'h322);
    run_instr(8'hD0, 0);
    chk("sub_jc_taken", imem_addr, 12'h322);

    // Jumps from reset state: JP, JZ with Z=0, JNZ with Z=0.
    do_reset();
    run_instr(8'hA0, 0); run_instr(8'hA1, 0); run_instr(8'hA0, 0);
    run_instr(8'hC0, 0);
    chk("jp_pc", imem_addr, 12'h010);
    do_reset();
    run_instr(8'hA0, 0); run_instr(8'hA1, 0); run_instr(8'hA0, 0);
    run_instr(8'hE0, 2);
    chk("jz_not_taken_pc", imem_addr, 12'h004);
    do_reset();
    run_instr(8'hA0, 0); run_instr(8'hA1, 0); run_instr(8'hA0, 0);
    run_instr(8'hF0, 0);
    chk("jnz_taken_pc", imem_addr, 12'h010);

    // Wait states, then LI 0xA; ST 7; LD 7; ADD 2 -> A=B=0xA so dmem[2]=4.
    run_instr(8'hA7, 3);
    run_instr(8'hAA, 0);
    run_instr(8'h07, 3);
    chk("st7_ram", ram[7], 4'hA);
    run_instr(8'h87, 0);
    run_instr(8'h22, 0);
    chk("ld_add_ram2", ram[2], 4'h4);

    // Reset asserted during the EXEC of a store: write is dropped.
    saved = ram[5];
    imem_ready = 1'b1;
    imem_rdata = 8'h05;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("abort_we_before", dmem_we, 1);
    nReset = 1'b0;
    #1;
    chk("abort_we_async", dmem_we, 0);
    @(negedge clk);
    chk("abort_no_write", ram[5], saved);
    chk("abort_pc", imem_addr, 0);
    nReset = 1'b1;
    model_reset();

    // Random programs against the model.
    for (int n = 0; n < 400; n++) begin
      ins = 8'($urandom);
      if (ins == 8'hBF) ins = 8'hB0;
      run_instr(ins, int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== 4'(m_ram[i])) chk("ram_final", ram[i], 4'(m_ram[i]));
    end
    total++;

    // HALT holds forever until reset.
    run_instr(8'hBF, 1);
    for (int k = 0; k < 5; k++) begin
      imem_ready = 1'($urandom);
      chk("halt_flag", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_we", dmem_we, 0);
      @(negedge clk);
    end
    do_reset();
    run_instr(8'hD0, 0);
    chk("post_reset_c", imem_addr, 12'h001);
    run_instr(8'hE0, 0);
    chk("post_reset_z", imem_addr, 12'h002);
    run_instr(8'h10, 0);
    chk("post_reset_stack", ram[0], 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hcx_core.md
# hcx_core

- Parametrised successor to the 4-bit HC-series stack CPU. Generalises data width, stack depth and PC width.
- Runs on a single clock edge as a FETCH/EXEC state machine, replacing the two-edge scheme.
- Moves instruction and data memory outside the core, behind request/ready and write-enable ports.
- Sits between an external program ROM and data RAM. Adds JNZ, HALT and fetch wait-states.

## Interface
- `DATA_W`, 4: datapath width (stack entries, ALU, RAM words); ≥4.
- `STACK_DEPTH`, 3: number of stack levels (A = top); ≥3.
- `PC_W`, 12: program-counter width.
- `clk` in 1: clock; all state changes on posedge.
- `nReset` in 1: asynchronous, active-low reset.
- `imem_addr` out PC_W: fetch address (= pc).
- `imem_req` out 1: high in FETCH.
- `imem_ready` in 1: `imem_rdata` valid this cycle.
- `imem_rdata` in 8: instruction byte.
- `dmem_addr` out 2*DATA_W: data address.
- `dmem_wdata` out DATA_W: write data.
- `dmem_we` out 1: write strobe; memory writes on posedge.
- `dmem_rdata` in DATA_W: combinational read data for `dmem_addr`.
- `halted` out 1: core stopped.
- `dbg_pc` out PC_W, `dbg_instr` out 8, `dbg_alu` out DATA_W: present only with `HCX_DEBUG_EN`.

## Operation
- Reset state: state=FETCH, pc=0, instruction reg=0, all stack levels=0, C=0, Z=0, `halted`=0, `dmem_we`=0, `imem_addr`=0.
- FETCH:
  - Drive `imem_req`=1 and `imem_addr`=pc.
  - When `imem_ready`=1, latch `imem_rdata` and go to EXEC.
  - Otherwise stay in FETCH with all state held.
- EXEC: executes for one cycle and returns to FETCH. pc←pc+1 modulo 2^PC_W unless a jump is taken.
- Instruction set; `r` = instr[3:0] zero-extended to 2*DATA_W; `i` = instr[3:0] zero-extended to DATA_W:
  - 0000 r: ST, RAM[r]←A.
  - 0001 x: ST [AB], RAM[{B,A}]←C-level.
  - 0010 r: ADD, RAM[r]←A+B; C←carry out of bit DATA_W-1.
  - 0011 r: SUB, RAM[r]←A+~B+1; C←carry (1 = no borrow).
  - 0100 r: AND. 0101 r: OR. 0110 r: XOR. 0111 r: NOR.
  - Every 0xxx instruction sets Z←(written data==0). C is updated only by ADD and SUB. The stack is unchanged.
  - 1000 r: LD, push RAM[r].
  - 1001 x: LD [AB], push RAM[{B,A}].
  - 1010 i: LI, push i.
  - 1011 x with x≠F: NOP. 1011 1111: HALT.
  - 11cc x: jump; cc=00 JP, 01 JC (C=1), 10 JZ (Z=1), 11 JNZ (Z=0).
  - Jump target = {C-level,B,A} (3*DATA_W bits), truncated or zero-extended to PC_W. Not taken → pc+1.
- Push: every level shifts down one place and the bottom level is discarded. There are no overflow or underflow flags.
- HALT: set `halted`, enter HALT state, hold `imem_req`=0. Only reset leaves HALT.

## Timing
- Each instruction takes one FETCH cycle plus wait cycles, then one EXEC cycle. The minimum is 2 clocks per instruction.
- `dmem_addr` and `dmem_wdata` are valid throughout EXEC. `dmem_we`=1 only in the EXEC of ST/ALU ops. The RAM captures the write at the EXEC→FETCH edge.
- Loads sample `dmem_rdata` in EXEC and push it at the end of EXEC.
- Flags update at the end of EXEC. A following jump sees the new flags.
- `imem_ready` is ignored outside FETCH. `imem_addr` is stable for the whole of FETCH, including wait cycles.
- Reset asserted mid-FETCH or mid-EXEC: abort immediately. A pending write is not performed, and `dmem_we` drops asynchronously.

## Configuration
- `HCX_DEBUG_EN` defined:
  - `dbg_pc`=pc, `dbg_instr`=instruction register, `dbg_alu`=combinational ALU output.
  - All three reset to 0.
- Not defined: the debug ports and their logic are absent. Functional behaviour is identical.

## Test plan
All cases use default parameters.
- Reset, then LI 3; LI 5; ADD 0 → write of 8 to dmem[0]; C=0, Z=0; pc=3.
- LI 5; LI 3; SUB 1 → dmem[1]=0xE, C=0. Then LI 2; LI 2; SUB 1 → dmem[1]=0, C=1, Z=1.
- LI 0; LI 1; LI 0; JP → pc=0x010. Repeat with JZ when Z=0 → pc=4. JNZ when Z=0 → 0x010.
- Hold `imem_ready` low for 3 cycles in FETCH → `imem_addr` and `imem_req` stable, no state change; the instruction executes 1 cycle after ready.
- LI 0xA; ST 7; LD 7 → A=0xA, B=0xA; `dmem_we` is high for exactly one cycle.
- HALT → `halted`=1 and `imem_req`=0 indefinitely. Pulse `nReset` low → `halted`=0, pc=0, stack and flags=0.
